// File: rtl/reg_dump_ctrl.sv
// Board-level register dump: freezes the CPU at HALT_PC (or after a cycle budget) and streams
// PC, instruction and every RF register as tagged 32-bit words over a valid/ready port.
module reg_dump_ctrl #(
    parameter logic [31:0] HALT_PC    = 32'h0000_0048,
    parameter int unsigned MAX_CYCLES = 1000,
    parameter int unsigned NREGS      = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    output logic        cpu_freeze,
    output logic [4:0]  reg_sel,
    input  logic [31:0] reg_data,
    output logic [31:0] dout,
    output logic [5:0]  dout_tag,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        done,
    output logic        timeout,
    output logic [2:0]  dbg_state
);

    // Stream handshake: a word transfers on the rising edge where dout_valid && dout_ready.
    // dout/dout_tag are held while valid is high and not yet accepted; valid then drops for
    // at least one cycle before the next word. dout_ready may be high before valid.

    localparam int unsigned CW       = $clog2(MAX_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [5:0]    LAST_TAG = 6'(NREGS + 1);

    typedef enum logic [2:0] {
        S_RUN  = 3'd0,
        S_SEL  = 3'd1,
        S_CAP  = 3'd2,
        S_SEND = 3'd3,
        S_DONE = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pc_lat_q, pc_lat_d;
    logic [31:0]   instr_lat_q, instr_lat_d;
    logic [5:0]    idx_q, idx_d;
    logic          freeze_q, freeze_d;
    logic [4:0]    reg_sel_q, reg_sel_d;
    logic [31:0]   dout_q, dout_d;
    logic [5:0]    tag_q, tag_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          timeout_q, timeout_d;
    logic          leave_run;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_RUN;
            cnt_q       <= '0;
            pc_lat_q    <= '0;
            instr_lat_q <= '0;
            idx_q       <= '0;
            freeze_q    <= 1'b0;
            reg_sel_q   <= '0;
            dout_q      <= '0;
            tag_q       <= '0;
            valid_q     <= 1'b0;
            done_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pc_lat_q    <= pc_lat_d;
            instr_lat_q <= instr_lat_d;
            idx_q       <= idx_d;
            freeze_q    <= freeze_d;
            reg_sel_q   <= reg_sel_d;
            dout_q      <= dout_d;
            tag_q       <= tag_d;
            valid_q     <= valid_d;
            done_q      <= done_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_lat_d    = pc_lat_q;
        instr_lat_d = instr_lat_q;
        idx_d       = idx_q;
        freeze_d    = freeze_q;
        reg_sel_d   = reg_sel_q;
        dout_d      = dout_q;
        tag_d       = tag_q;
        valid_d     = valid_q;
        done_d      = done_q;
        timeout_d   = timeout_q;
        leave_run   = 1'b0;

        case (state_q)
            S_RUN: begin
                cnt_d = cnt_q + CNT_ONE;
                // HALT_PC takes priority when it coincides with the last budget cycle.
                if (pc == HALT_PC) begin
                    leave_run = 1'b1;
                    timeout_d = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    leave_run = 1'b1;
                    timeout_d = 1'b1;
                end
                if (leave_run) begin
                    cnt_d       = cnt_q;
                    state_d     = S_SEL;
                    pc_lat_d    = pc;
                    instr_lat_d = instr;
                    freeze_d    = 1'b1;
                    idx_d       = '0;
                end
            end

            S_SEL: begin
                if (idx_q == 6'd0) begin
                    dout_d  = pc_lat_q;
                    tag_d   = idx_q;
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end else if (idx_q == 6'd1) begin
                    dout_d  = instr_lat_q;
                    tag_d   = idx_q;
                    valid_d = 1'b1;
                    state_d = S_SEND;
                end else begin
                    // Register words: select now, sample a full cycle later in CAP.
                    reg_sel_d = 5'(idx_q - 6'd2);
                    state_d   = S_CAP;
                end
            end

            S_CAP: begin
                dout_d  = reg_data;
                tag_d   = idx_q;
                valid_d = 1'b1;
                state_d = S_SEND;
            end

            S_SEND: begin
                if (dout_ready) begin
                    valid_d = 1'b0;
                    if (idx_q == LAST_TAG) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = S_SEL;
                    end
                end
            end

            S_DONE: begin
                valid_d = 1'b0;
            end

            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    assign cpu_freeze = freeze_q;
    assign reg_sel    = reg_sel_q;
    assign dout       = dout_q;
    assign dout_tag   = tag_q;
    assign dout_valid = valid_q;
    assign done       = done_q;
    assign timeout    = timeout_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// Randomized scoreboard bench for reg_dump_ctrl: a per-cycle pc/instr plan drives the CPU side,
// a reference model predicts the halt cycle and the word stream, a monitor checks every transfer.
module tb_reg_dump_ctrl;

    localparam logic [31:0] HALT_PC = 32'h0000_0048;
    localparam int MAX_CYCLES = 1000;
    localparam int NREGS = 32;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] instr = '0;
    logic        cpu_freeze;
    logic [4:0]  reg_sel;
    logic [31:0] reg_data;
    logic [31:0] dout;
    logic [5:0]  dout_tag;
    logic        dout_valid;
    logic        dout_ready = 1'b1;
    logic        done;
    logic        timeout;
    logic [2:0]  dbg_state;

    logic [31:0] rf_mem [NREGS];
    logic [31:0] pc_plan [1:MAX_CYCLES];
    logic [31:0] instr_plan [1:MAX_CYCLES];
    logic [31:0] exp_q [$];
    logic [5:0]  exp_tag_q [$];

    int n_checks = 0;
    int n_pass = 0;
    bit rdy_random = 1'b0;

    reg_dump_ctrl #(.HALT_PC(HALT_PC), .MAX_CYCLES(MAX_CYCLES), .NREGS(NREGS)) dut (
        .clk(clk), .rstn(rstn), .pc(pc), .instr(instr),
        .cpu_freeze(cpu_freeze), .reg_sel(reg_sel), .reg_data(reg_data),
        .dout(dout), .dout_tag(dout_tag), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .done(done), .timeout(timeout), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    assign reg_data = rf_mem[reg_sel];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_all_zero(input string where);
        check({where, "_freeze"}, {31'd0, cpu_freeze}, 32'd0);
        check({where, "_reg_sel"}, {27'd0, reg_sel}, 32'd0);
        check({where, "_dout"}, dout, 32'd0);
        check({where, "_tag"}, {26'd0, dout_tag}, 32'd0);
        check({where, "_valid"}, {31'd0, dout_valid}, 32'd0);
        check({where, "_done"}, {31'd0, done}, 32'd0);
        check({where, "_timeout"}, {31'd0, timeout}, 32'd0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        #2 rstn = 1'b0;
        #1 check_all_zero("reset");
        exp_q.delete();
        exp_tag_q.delete();
        repeat (2) @(posedge clk);
    endtask

    // ---------------- ready driver ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1 dout_ready = rdy_random ? ($urandom_range(0, 99) < 30) : 1'b1;
        end
    end

    // ---------------- stimulus plans ----------------
    function automatic logic [31:0] non_halt_pc();
        logic [31:0] v;
        v = {14'd0, 16'($urandom_range(0, 16'hffff)), 2'b00};
        if (v == HALT_PC) v = v + 32'd4;
        return v;
    endfunction

    // mode 0: sequential pc from 0; 1: never halts; 2: halt exactly on budget cycle; 3: random halt
    task automatic build_plan(input int mode);
        int hk;
        hk = $urandom_range(2, 200);
        for (int k = 1; k <= MAX_CYCLES; k++) begin
            instr_plan[k] = $urandom;
            case (mode)
                0: pc_plan[k] = 32'(4 * (k - 1));
                2: pc_plan[k] = (k == MAX_CYCLES) ? HALT_PC : non_halt_pc();
                3: pc_plan[k] = (k == hk) ? HALT_PC : non_halt_pc();
                default: pc_plan[k] = non_halt_pc();
            endcase
        end
    endtask

    // Reference model: first cycle whose pc is HALT_PC, else the last budget cycle.
    task automatic model_push(output int halt_k, output bit exp_tmo);
        halt_k = MAX_CYCLES;
        exp_tmo = 1'b1;
        for (int k = 1; k <= MAX_CYCLES; k++) begin
            if (pc_plan[k] == HALT_PC) begin
                halt_k = k;
                exp_tmo = 1'b0;
                break;
            end
        end
        exp_q.push_back(pc_plan[halt_k]);
        exp_tag_q.push_back(6'd0);
        exp_q.push_back(instr_plan[halt_k]);
        exp_tag_q.push_back(6'd1);
        for (int i = 0; i < NREGS; i++) begin
            exp_q.push_back(rf_mem[i]);
            exp_tag_q.push_back(6'(i + 2));
        end
    endtask

    task automatic run_test(input string name, input int mode, input bit rand_ready,
                            input int abort_tag);
        int halt_k;
        bit exp_tmo;
        int k;
        int n;
        bit frozen;
        apply_reset();
        rdy_random = rand_ready;
        build_plan(mode);
        model_push(halt_k, exp_tmo);
        @(negedge clk);
        rstn = 1'b1;
        k = 1;
        pc = pc_plan[1];
        instr = instr_plan[1];
        frozen = 1'b0;
        while (!frozen && k <= MAX_CYCLES) begin
            @(negedge clk);
            if (cpu_freeze) frozen = 1'b1;
            else begin
                k++;
                if (k <= MAX_CYCLES) begin
                    pc = pc_plan[k];
                    instr = instr_plan[k];
                end
            end
        end
        check({name, "_freeze_cycle"}, 32'(k), 32'(halt_k));
        if (!frozen) return;
        // Revisiting HALT_PC after the freeze must not disturb the dump.
        pc = HALT_PC;
        instr = $urandom;
        if (abort_tag >= 0) begin
            n = 0;
            while (!(dout_valid && dout_tag == 6'(abort_tag)) && n < 2000) begin
                @(negedge clk);
                n++;
            end
            check({name, "_abort_reached"}, {31'd0, dout_valid}, 32'd1);
            #2 rstn = 1'b0;
            #1 check_all_zero({name, "_abort"});
            exp_q.delete();
            exp_tag_q.delete();
            return;
        end
        n = 0;
        while (!done && n < 6000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_done"}, {31'd0, done}, 32'd1);
        if (!rand_ready) check({name, "_done_latency"}, 32'(n), 32'(4 + 3 * NREGS));
        check({name, "_timeout"}, {31'd0, timeout}, {31'd0, exp_tmo});
        check({name, "_words_left"}, 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        check({name, "_done_sticky"}, {31'd0, done}, 32'd1);
        check({name, "_freeze_held"}, {31'd0, cpu_freeze}, 32'd1);
        check({name, "_valid_idle"}, {31'd0, dout_valid}, 32'd0);
        check({name, "_reg_sel_last"}, {27'd0, reg_sel}, 32'(NREGS - 1));
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        bit stall_p;
        bit hs_p;
        logic [31:0] prev_d;
        logic [5:0] prev_t;
        stall_p = 1'b0;
        hs_p = 1'b0;
        prev_d = '0;
        prev_t = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                stall_p = 1'b0;
                hs_p = 1'b0;
            end else begin
                if (stall_p) begin
                    check("valid_held", {31'd0, dout_valid}, 32'd1);
                    check("dout_stable", dout, prev_d);
                    check("tag_stable", {26'd0, dout_tag}, {26'd0, prev_t});
                end
                if (hs_p) check("valid_gap", {31'd0, dout_valid}, 32'd0);
                if (dout_valid && dout_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        $display("FAIL unexpected_word: got tag %0d data %h expected no word",
                                 dout_tag, dout);
                    end else begin
                        check("word_tag", {26'd0, dout_tag}, {26'd0, exp_tag_q.pop_front()});
                        check("word_data", dout, exp_q.pop_front());
                    end
                end
                stall_p = dout_valid && !dout_ready;
                hs_p = dout_valid && dout_ready;
                prev_d = dout;
                prev_t = dout_tag;
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        for (int i = 0; i < NREGS; i++) rf_mem[i] = $urandom;
        run_test("halt_seq", 0, 1'b0, -1);
        for (int i = 0; i < NREGS; i++) rf_mem[i] = $urandom;
        run_test("budget", 1, 1'b0, -1);
        run_test("backpressure_a", 3, 1'b1, -1);
        for (int i = 0; i < NREGS; i++) rf_mem[i] = $urandom;
        run_test("backpressure_b", 0, 1'b1, -1);
        run_test("halt_on_last", 2, 1'b0, -1);
        run_test("abort", 0, 1'b0, 10);
        run_test("after_abort", 0, 1'b0, -1);
        for (int i = 0; i < NREGS; i++) rf_mem[i] = 32'hA5A5_0000 + 32'(i);
        run_test("rf_pattern", 3, 1'b0, -1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
